// File: rtl/text_char_buffer_pkg.sv
// text_pkg: shared constants, FSM state type and cell-address packing for the text overlay buffer.
package text_pkg;
  localparam int TXT_COLS = 32;
  localparam int TXT_ROWS = 8;
  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic [6:0] CHAR_NL = 7'h0A;
  typedef enum logic {CLEAR, IDLE} txt_state_t;
  function automatic logic [7:0] cell_addr(input logic [2:0] row, input logic [4:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/text_char_buffer_if.sv
// text_char_buffer_if: write/control port from the game FSM and read port from the text drawing stage.
interface text_char_buffer_if;
  logic clear;
  logic cur_set;
  logic [2:0] cur_row_in;
  logic [4:0] cur_col_in;
  logic wr_valid;
  logic [6:0] wr_char;
  logic wr_ready;
  logic busy;
  logic [11:0] rd_xy;
  logic [3:0] rd_line;
  logic [6:0] char_code;
  logic [3:0] char_line_out;
  modport master(
    output clear, cur_set, cur_row_in, cur_col_in, wr_valid, wr_char, rd_xy, rd_line,
    input wr_ready, busy, char_code, char_line_out
  );
  modport slave(
    input clear, cur_set, cur_row_in, cur_col_in, wr_valid, wr_char, rd_xy, rd_line,
    output wr_ready, busy, char_code, char_line_out
  );
endinterface

// File: rtl/text_char_buffer_char_ram.sv
// char_ram: 256x7 simple dual-port RAM, synchronous write, read-first synchronous read, no reset.
module char_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] wa,
  input  logic [6:0] wd,
  input  logic [7:0] ra,
  output logic [6:0] rd
);
  logic [6:0] mem [256];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/text_char_buffer.sv
// text_char_buffer: character-cell store with auto-advancing write cursor and 1-cycle read to the font ROM.
module text_char_buffer
  import text_pkg::*;
(
  input logic clk,
  input logic rst_n,
  text_char_buffer_if.slave bus
);
  txt_state_t state;
  logic [7:0] clr_idx;
  logic [2:0] row;
  logic [4:0] col;
  logic win_q;
  logic [6:0] ram_q;
  logic acc, nl, we;
  logic [7:0] wa;
  logic [6:0] wd;
  assign bus.wr_ready = state == IDLE && !bus.clear && !bus.cur_set;
  assign bus.busy = state == CLEAR;
  always_comb begin
    acc = bus.wr_valid && bus.wr_ready;
    nl = bus.wr_char == CHAR_NL;
    we = bus.busy || (acc && !nl);
    wa = bus.busy ? clr_idx : cell_addr(row, col);
    wd = bus.busy ? CHAR_SPACE : bus.wr_char;
  end
  char_ram u_ram (
    .clk(clk),
    .we(we),
    .wa(wa),
    .wd(wd),
    .ra(cell_addr(bus.rd_xy[10:8], bus.rd_xy[4:0])),
    .rd(ram_q)
  );
  // Out-of-window reads and the post-reset output both show a blank cell.
  assign bus.char_code = win_q ? ram_q : CHAR_SPACE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= 1'b0;
      bus.char_line_out <= '0;
    end else begin
      win_q <= !bus.rd_xy[11] && bus.rd_xy[7:5] == 3'd0;
      bus.char_line_out <= bus.rd_line;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_idx <= '0;
      row <= '0;
      col <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 8'd1;
      if (clr_idx == 8'hFF) begin
        state <= IDLE;
        row <= '0;
        col <= '0;
      end
    end else if (bus.clear) begin
      clr_idx <= '0;
      state <= CLEAR;
    end else if (bus.cur_set) begin
      row <= bus.cur_row_in;
      col <= bus.cur_col_in;
    end else if (acc) begin
      col <= nl ? 5'd0 : col + 5'd1;
      row <= (nl || col == 5'(TXT_COLS - 1)) ? row + 3'd1 : row;
    end
  end
endmodule
